// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared types, defaults and trellis helpers for the Viterbi traceback
package viterbi_pkg;

  localparam int NUM_STATES_DEF = 4;
  localparam int TAIL_LEN_DEF   = 2;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    TRACE = 2'd1,
    OUT   = 2'd2
  } trace_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // predecessor of state s given its decision bit d: {s[w-2:0], d}
  function automatic logic [31:0] pred(input int w, input logic [31:0] s, input logic d);
    return ((s << 1) | 32'(d)) & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/survivor_ram.sv
// rtl/survivor_ram.sv - survivor decision store, synchronous write and asynchronous read
module survivor_ram #(
  parameter int Depth = 64,
  parameter int Width = 4,
  parameter int AW    = 6
) (
  input  logic             mclk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [Width-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge mclk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/viterbi_traceback.sv
// rtl/viterbi_traceback.sv - frame-based traceback from state 0, emits decoded bits in order
module viterbi_traceback
  import viterbi_pkg::*;
#(
  parameter int Num_States = NUM_STATES_DEF,
  parameter int Frame_Len  = 64,
  parameter int Tail_Len   = TAIL_LEN_DEF
) (
  input  logic                  mclk,
  input  logic                  rst,
  input  logic [Num_States-1:0] dec_in,
  input  logic                  dec_valid,
  output logic                  dec_ready,
  output logic                  bit_out,
  output logic                  bit_valid,
  input  logic                  bit_ready,
  output logic                  bit_last,
  output logic                  busy
);

  localparam int W  = clog2(Num_States);
  localparam int AW = clog2(Frame_Len);
  localparam logic [AW-1:0] LAST_WR = AW'(Frame_Len - 1);
  localparam logic [AW-1:0] LAST_RD = AW'(Frame_Len - Tail_Len - 1);

  trace_state_t state, state_nxt;
  logic [AW-1:0] wr_ptr, t_ptr, rd_ptr;
  logic [W-1:0] cur;
  logic [Num_States-1:0] surv_rd;
  logic bitbuf [Frame_Len];
  logic dec_hs, bit_hs;

  assign dec_hs = (state == FILL) && dec_valid;
  assign bit_hs = (state == OUT) && bit_ready;

  survivor_ram #(
    .Depth(Frame_Len),
    .Width(Num_States),
    .AW(AW)
  ) u_survivor (
    .mclk (mclk),
    .we   (dec_hs),
    .waddr(wr_ptr),
    .wdata(dec_in),
    .raddr(t_ptr),
    .rdata(surv_rd)
  );

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (dec_hs && wr_ptr == LAST_WR) state_nxt = TRACE;
      TRACE:   if (t_ptr == '0) state_nxt = OUT;
      OUT:     if (bit_hs && rd_ptr == LAST_RD) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      t_ptr  <= '0;
      rd_ptr <= '0;
      cur    <= '0;
    end else begin
      case (state)
        FILL: begin
          if (dec_hs) begin
            wr_ptr <= (wr_ptr == LAST_WR) ? '0 : wr_ptr + AW'(1);
            // a terminated frame always ends in state 0
            if (wr_ptr == LAST_WR) begin
              t_ptr <= LAST_WR;
              cur   <= '0;
            end
          end
        end
        TRACE: begin
          cur   <= W'(pred(W, 32'(cur), surv_rd[cur]));
          t_ptr <= t_ptr - AW'(1);
          if (t_ptr == '0) rd_ptr <= '0;
        end
        OUT: begin
          if (bit_hs) rd_ptr <= rd_ptr + AW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge mclk) begin
    if (state == TRACE) bitbuf[t_ptr] <= cur[W-1];
  end

  assign dec_ready = (state == FILL);
  assign busy      = (state != FILL);
  assign bit_valid = (state == OUT);
  assign bit_out   = (state == OUT) ? bitbuf[rd_ptr] : 1'b0;
  assign bit_last  = (state == OUT) && (rd_ptr == LAST_RD);

endmodule

// File: tb/tb_viterbi_traceback.sv
// tb/tb_viterbi_traceback.sv - randomized self-checking bench for viterbi_traceback
module tb_viterbi_traceback;

  localparam int NS   = 4;
  localparam int W    = 2;
  localparam int FL   = 64;
  localparam int TL   = 2;
  localparam int OUTN = FL - TL;

  typedef logic [NS-1:0] frame_t [FL];

  logic mclk = 1'b0;
  logic rst = 1'b1;
  logic [NS-1:0] dec_in = '0;
  logic dec_valid = 1'b0;
  logic dec_ready;
  logic bit_out, bit_valid, bit_last, busy;
  logic bit_ready = 1'b1;

  viterbi_traceback #(.Num_States(NS), .Frame_Len(FL), .Tail_Len(TL)) dut (
    .mclk(mclk), .rst(rst), .dec_in(dec_in), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .bit_out(bit_out), .bit_valid(bit_valid), .bit_ready(bit_ready), .bit_last(bit_last),
    .busy(busy)
  );

  always #5 mclk = ~mclk;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int rx_idx = 0;
  int first_cyc = -1;
  int last_acc = 0;
  bit expect_out = 1'b0;
  bit ready_rand = 1'b0;
  logic [FL-1:0] exp_all = '0;
  bit prev_stall = 1'b0;
  logic prev_out = 1'b0, prev_last = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  always @(posedge mclk) cyc <= cyc + 1;

  initial forever begin
    @(posedge mclk);
    #1;
    bit_ready = ready_rand ? 1'($urandom % 2) : 1'b1;
  end

  // output monitor: compares against the expected frame on every cycle
  always @(negedge mclk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (bit_valid) begin
        if (!expect_out || rx_idx >= OUTN) begin
          chk("unexpected_valid", 64'(bit_valid), 64'd0);
        end else begin
          if (first_cyc < 0) first_cyc = cyc;
          chk("bit_out", 64'(bit_out), 64'(exp_all[rx_idx]));
          chk("bit_last", 64'(bit_last), 64'(rx_idx == OUTN - 1));
        end
        if (prev_stall) chk("stall_hold", {62'd0, bit_out, bit_last}, {62'd0, prev_out, prev_last});
        if (bit_ready) rx_idx++;
      end else if (prev_stall) begin
        chk("valid_dropped", 64'(bit_valid), 64'd1);
      end
      chk("ready_vs_busy", 64'(dec_ready), 64'(!busy));
      prev_stall = bit_valid && !bit_ready;
      prev_out = bit_out;
      prev_last = bit_last;
    end
  end

  function automatic logic [FL-1:0] model_decode(input frame_t fr);
    logic [FL-1:0] b;
    int s;
    s = 0;
    for (int t = FL - 1; t >= 0; t--) begin
      b[t] = 1'(s >> (W - 1));
      s = ((s << 1) | int'(fr[t][s])) % NS;
    end
    return b;
  endfunction

  // encode data through the K=3 trellis; the true path's decisions are set, others random
  function automatic frame_t gen_encoded(input logic [OUTN-1:0] data);
    frame_t fr;
    int s, ns, u;
    logic [NS-1:0] v;
    s = 0;
    for (int t = 0; t < FL; t++) begin
      u = (t < OUTN) ? int'(data[t]) : 0;
      ns = (u << (W - 1)) | (s >> 1);
      v = NS'($urandom);
      v[ns] = 1'(s & 1);
      fr[t] = v;
      s = ns;
    end
    return fr;
  endfunction

  task automatic send_frame(input frame_t fr, input bit gaps);
    for (int i = 0; i < FL; i++) begin
      if (gaps && ($urandom % 4 == 0)) begin
        dec_valid = 1'b0;
        dec_in = NS'($urandom);
        @(posedge mclk);
        #1;
      end
      chk("dec_ready_fill", 64'(dec_ready), 64'd1);
      dec_valid = 1'b1;
      dec_in = fr[i];
      @(posedge mclk);
      #1;
    end
    last_acc = cyc;
  endtask

  task automatic run_frame(input frame_t fr, input bit rnd_ready, input bit hold_dv, input bit gaps);
    int k;
    exp_all = model_decode(fr);
    rx_idx = 0;
    first_cyc = -1;
    expect_out = 1'b1;
    ready_rand = rnd_ready;
    send_frame(fr, gaps);
    dec_valid = hold_dv;
    k = 0;
    while (rx_idx < OUTN && k < 2000) begin
      @(negedge mclk);
      if (hold_dv) dec_in = NS'($urandom);
      k++;
    end
    chk("handshakes", 64'(rx_idx), 64'(OUTN));
    chk("latency", 64'(first_cyc - last_acc), 64'(FL));
    @(posedge mclk);
    dec_valid = 1'b0;
    ready_rand = 1'b0;
    @(negedge mclk);
    chk("ready_after_last", {61'd0, dec_ready, busy, bit_valid}, {61'd0, 3'b100});
  endtask

  frame_t fr;
  logic [OUTN-1:0] data;
  logic [FL-1:0] m;

  initial begin
    repeat (3) @(posedge mclk);
    @(negedge mclk);
    chk("rst_outputs", {59'd0, dec_ready, bit_valid, bit_out, bit_last, busy}, {59'd0, 5'b10000});
    #1 rst = 1'b0;
    @(negedge mclk);
    chk("post_rst_outputs", {59'd0, dec_ready, bit_valid, bit_out, bit_last, busy}, {59'd0, 5'b10000});

    for (int t = 0; t < FL; t++) fr[t] = '0;
    m = model_decode(fr);
    chk("pin_zero", 64'(m), 64'd0);
    run_frame(fr, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < FL; t++) fr[t] = '1;
    m = model_decode(fr);
    chk("pin_ones", 64'(m), 64'h3FFF_FFFF_FFFF_FFFF);
    run_frame(fr, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 5; n++) begin
      data = {$urandom, $urandom};
      fr = gen_encoded(data);
      m = model_decode(fr);
      chk("pin_encoded", 64'(m[OUTN-1:0]), 64'(data));
      run_frame(fr, n >= 1, n >= 2, n >= 3);
    end

    // reset during traceback
    data = {$urandom, $urandom};
    fr = gen_encoded(data);
    rx_idx = 0;
    expect_out = 1'b0;
    send_frame(fr, 1'b0);
    dec_valid = 1'b0;
    repeat (30) @(posedge mclk);
    #2 rst = 1'b1;
    @(negedge mclk);
    chk("rst_mid_trace", {61'd0, busy, dec_ready, bit_valid}, {61'd0, 3'b010});
    @(posedge mclk);
    #1 rst = 1'b0;
    repeat (80) @(negedge mclk);
    chk("after_rst_idle", {61'd0, busy, dec_ready, bit_valid}, {61'd0, 3'b010});

    data = {$urandom, $urandom};
    fr = gen_encoded(data);
    m = model_decode(fr);
    chk("pin_encoded_post_rst", 64'(m[OUTN-1:0]), 64'(data));
    run_frame(fr, 1'b1, 1'b0, 1'b0);

    repeat (5) @(negedge mclk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
